// File: rtl/cam_access_arbiter.sv
// ---------------------------------------------------------------------------
// cam_access_arbiter
//
// Shares one registered CAM (one-hot match output, multi-cycle write) between
// two lookup requesters (lk0, lk1) and one table-write requester (wr).
// Accesses are serialised by a small FSM:
//   IDLE   -> arbitrate (write first, lookups round-robin)
//   LOOKUP -> cam_rd_en pulse is on the bus
//   WAIT   -> LOOKUP_LATENCY cycles; result sampled in the last one
//   WRITE  -> cam_wr_en pulse is on the bus
//   BUSY   -> WR_BUSY_CYCLES cycles of CAM recovery; wr_ack follows
// Every output is registered. Lookup ack arrives 2+LOOKUP_LATENCY cycles after
// the grant cycle, write ack 2+WR_BUSY_CYCLES cycles after it.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   lkN_req/lkN_key                   lookup request (held until lkN_ack)
//   lkN_ack/lkN_hit/lkN_match_addr    one-cycle result pulse (hit/addr 0 otherwise)
//   wr_req/wr_addr/wr_key             write request (held until wr_ack)
//   wr_ack                            one-cycle pulse: write done, CAM free
//   cam_rd_en/cam_rd_key              CAM compare strobe and key
//   cam_match/cam_one_hot_addr        CAM result (valid LOOKUP_LATENCY after rd_en)
//   cam_wr_en/cam_wr_key/cam_wr_index CAM write strobe, key and entry
//
// Optional build macro CAM_ARB_STATS_EN adds:
//   stats_clr                         synchronous clear of the counters
//   stat_lookups/stat_hits/stat_writes 32-bit wrapping event counters
// ---------------------------------------------------------------------------
module cam_access_arbiter #(
  parameter int CMP_WIDTH      = 32,
  parameter int LUT_DEPTH      = 32,
  parameter int LUT_DEPTH_BITS = 5,
  parameter int LOOKUP_LATENCY = 1,
  parameter int WR_BUSY_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // lookup requester 0
  input  logic                      lk0_req,
  input  logic [CMP_WIDTH-1:0]      lk0_key,
  output logic                      lk0_ack,
  output logic                      lk0_hit,
  output logic [LUT_DEPTH-1:0]      lk0_match_addr,
  // lookup requester 1
  input  logic                      lk1_req,
  input  logic [CMP_WIDTH-1:0]      lk1_key,
  output logic                      lk1_ack,
  output logic                      lk1_hit,
  output logic [LUT_DEPTH-1:0]      lk1_match_addr,
  // table writer
  input  logic                      wr_req,
  input  logic [LUT_DEPTH_BITS-1:0] wr_addr,
  input  logic [CMP_WIDTH-1:0]      wr_key,
  output logic                      wr_ack,
  // CAM side
  output logic                      cam_rd_en,
  output logic [CMP_WIDTH-1:0]      cam_rd_key,
  input  logic                      cam_match,
  input  logic [LUT_DEPTH-1:0]      cam_one_hot_addr,
  output logic                      cam_wr_en,
  output logic [CMP_WIDTH-1:0]      cam_wr_key,
  output logic [LUT_DEPTH_BITS-1:0] cam_wr_index
`ifdef CAM_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [31:0]               stat_lookups,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_writes
`endif
);

  localparam int NUM_LK  = 2;
  // WAIT and BUSY share one down-the-line counter sized for the longer phase.
  localparam int MAX_CNT = (LOOKUP_LATENCY > WR_BUSY_CYCLES) ? LOOKUP_LATENCY : WR_BUSY_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    BUSY   = 3'd4
  } state_t;

  state_t                                 state;
  logic   [CNT_W-1:0]                     cnt;
  logic                                   gnt;      // lookup lane currently served
  logic                                   rr_last;  // lane granted most recently
  logic   [NUM_LK-1:0]                    lk_ack;
  logic   [NUM_LK-1:0]                    lk_hit;
  logic   [NUM_LK-1:0][LUT_DEPTH-1:0]     lk_addr;

  // Lanes packed so arbitration and result steering index by lane number.
  logic   [NUM_LK-1:0]                    lk_req;
  logic   [NUM_LK-1:0][CMP_WIDTH-1:0]     lk_key;
  logic   [NUM_LK-1:0]                    lk_elig;
  logic                                   wr_elig;
  logic                                   pick;

  assign lk_req = {lk1_req, lk0_req};
  assign lk_key = {lk1_key, lk0_key};

  assign lk0_ack        = lk_ack[0];
  assign lk0_hit        = lk_hit[0];
  assign lk0_match_addr = lk_addr[0];
  assign lk1_ack        = lk_ack[1];
  assign lk1_hit        = lk_hit[1];
  assign lk1_match_addr = lk_addr[1];

  // A requester being acked this cycle still has its req high (it only sees
  // the ack now), so it is masked to avoid granting the same request twice.
  always_comb begin
    lk_elig = lk_req & ~lk_ack;
    wr_elig = wr_req & ~wr_ack;
    pick    = 1'b0;
    if (&lk_elig) pick = ~rr_last;     // tie: the lane not served last
    else          pick = lk_elig[1];   // lone requester (or none)
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= 1'b0;
      rr_last      <= 1'b1;            // lk0 wins the first tie
      lk_ack       <= '0;
      lk_hit       <= '0;
      lk_addr      <= '0;
      wr_ack       <= 1'b0;
      cam_rd_en    <= 1'b0;
      cam_rd_key   <= '0;
      cam_wr_en    <= 1'b0;
      cam_wr_key   <= '0;
      cam_wr_index <= '0;
    end else begin
      // Pulses default low; keys/index hold their last value.
      lk_ack    <= '0;
      lk_hit    <= '0;
      lk_addr   <= '0;
      wr_ack    <= 1'b0;
      cam_rd_en <= 1'b0;
      cam_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_elig) begin
            state        <= WRITE;
            cam_wr_en    <= 1'b1;
            cam_wr_key   <= wr_key;
            cam_wr_index <= wr_addr;
          end else if (|lk_elig) begin
            state      <= LOOKUP;
            gnt        <= pick;
            rr_last    <= pick;
            cam_rd_en  <= 1'b1;
            cam_rd_key <= lk_key[pick];
          end
        end
        LOOKUP: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (cnt == CNT_W'(LOOKUP_LATENCY - 1)) begin
            state        <= IDLE;
            lk_ack[gnt]  <= 1'b1;
            lk_hit[gnt]  <= cam_match;
            // CAM one-hot is not trusted on a miss.
            lk_addr[gnt] <= cam_match ? cam_one_hot_addr : '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          state <= BUSY;
          cnt   <= '0;
        end
        BUSY: begin
          if (cnt == CNT_W'(WR_BUSY_CYCLES - 1)) begin
            state  <= IDLE;
            wr_ack <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAM_ARB_STATS_EN
  // Counters follow the ack pulses, so they lag the ack by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_writes  <= '0;
    end else if (stats_clr) begin
      stat_lookups <= '0;
      stat_hits    <= '0;
      stat_writes  <= '0;
    end else begin
      if (|lk_ack)            stat_lookups <= stat_lookups + 32'd1;
      if (|(lk_ack & lk_hit)) stat_hits    <= stat_hits + 32'd1;
      if (wr_ack)             stat_writes  <= stat_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cam_access_arbiter
//
// Bench for cam_access_arbiter with a behavioural registered CAM (1-cycle
// read latency, programmable miss noise on the one-hot bus). Expected acks are
// queued when a request is driven and popped by a negedge monitor. Lookup
// vectors are table-driven; round-robin, write/lookup collision, reset abort
// and (with CAM_ARB_STATS_EN) the counters are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cam_access_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lk0_req, lk1_req, wr_req;
  logic [31:0] lk0_key, lk1_key, wr_key;
  logic [4:0]  wr_addr;
  logic        lk0_ack, lk0_hit, lk1_ack, lk1_hit, wr_ack;
  logic [31:0] lk0_match_addr, lk1_match_addr;
  logic        cam_rd_en, cam_wr_en;
  logic [31:0] cam_rd_key, cam_wr_key;
  logic [4:0]  cam_wr_index;
  logic        cam_match = 1'b0;
  logic [31:0] cam_one_hot_addr = 32'h0;
`ifdef CAM_ARB_STATS_EN
  logic        stats_clr;
  logic [31:0] stat_lookups, stat_hits, stat_writes;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cam_access_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .lk0_req         (lk0_req),
    .lk0_key         (lk0_key),
    .lk0_ack         (lk0_ack),
    .lk0_hit         (lk0_hit),
    .lk0_match_addr  (lk0_match_addr),
    .lk1_req         (lk1_req),
    .lk1_key         (lk1_key),
    .lk1_ack         (lk1_ack),
    .lk1_hit         (lk1_hit),
    .lk1_match_addr  (lk1_match_addr),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_key          (wr_key),
    .wr_ack          (wr_ack),
    .cam_rd_en       (cam_rd_en),
    .cam_rd_key      (cam_rd_key),
    .cam_match       (cam_match),
    .cam_one_hot_addr(cam_one_hot_addr),
    .cam_wr_en       (cam_wr_en),
    .cam_wr_key      (cam_wr_key),
    .cam_wr_index    (cam_wr_index)
`ifdef CAM_ARB_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .stat_lookups    (stat_lookups),
    .stat_hits       (stat_hits),
    .stat_writes     (stat_writes)
`endif
  );

  // ---------------- behavioural CAM ----------------
  logic [31:0] tbl [32] = '{0: 32'h01020304, 3: 32'h0A000001, 7: 32'hC0A80002,
                            31: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] tvalid = 32'h8000_0089;
  logic [31:0] noise = 32'h0;

  function automatic logic [31:0] cam_search(input logic [31:0] k);
    logic [31:0] oh;
    oh = '0;
    for (int i = 0; i < 32; i++) if (tvalid[i] && tbl[i] == k) oh[i] = 1'b1;
    return oh;
  endfunction

  always @(posedge clk) begin
    if (cam_wr_en) begin
      tbl[cam_wr_index]    <= cam_wr_key;
      tvalid[cam_wr_index] <= 1'b1;
    end
    if (cam_rd_en) begin
      cam_match        <= |cam_search(cam_rd_key);
      cam_one_hot_addr <= (|cam_search(cam_rd_key)) ? cam_search(cam_rd_key) : noise;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [1:0]  kind;   // 0 lk0, 1 lk1, 2 write
    logic        hit;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  // Scoreboard monitor: every ack pops the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [1:0] k;
    if (reset_n) begin
      if (!lk0_ack) chk("lk0_quiet", {lk0_hit, lk0_match_addr}, 64'h0);
      if (!lk1_ack) chk("lk1_quiet", {lk1_hit, lk1_match_addr}, 64'h0);
      if (lk0_ack || lk1_ack || wr_ack) begin
        chk("single_ack", 64'($countones({lk0_ack, lk1_ack, wr_ack})), 64'd1);
        k = wr_ack ? 2'd2 : (lk1_ack ? 2'd1 : 2'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: kind %0d acked with nothing outstanding", k);
        end else begin
          e = sb.pop_front();
          chk("sb_kind", 64'(k), 64'(e.kind));
          if (k == 2'd0) chk("lk0_result", {lk0_hit, lk0_match_addr}, {e.hit, e.addr});
          if (k == 2'd1) chk("lk1_result", {lk1_hit, lk1_match_addr}, {e.hit, e.addr});
        end
      end
    end
  end

  task automatic push_lk(input bit lane, input logic eh, input logic [31:0] ea);
    exp_t e;
    e.kind = {1'b0, lane};
    e.hit  = eh;
    e.addr = ea;
    sb.push_back(e);
  endtask

  task automatic do_lookup(input bit lane, input logic [31:0] key, input logic [31:0] nz,
                           input logic eh, input logic [31:0] ea);
    int n;
    noise = nz;
    if (lane) begin lk1_req = 1'b1; lk1_key = key; end
    else      begin lk0_req = 1'b1; lk0_key = key; end
    push_lk(lane, eh, ea);
    tick();
    chk("rd_en", 64'(cam_rd_en), 64'd1);
    chk("rd_key", 64'(cam_rd_key), 64'(key));
    n = 1;
    while (!(lane ? lk1_ack : lk0_ack) && n < 12) begin tick(); n++; end
    chk("lk_latency", 64'(n), 64'd3);
    lk0_req = 1'b0;
    lk1_req = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] key);
    exp_t e;
    int   n;
    wr_req = 1'b1; wr_addr = a; wr_key = key;
    e.kind = 2'd2; e.hit = 1'b0; e.addr = 32'h0;
    sb.push_back(e);
    tick();
    chk("wr_en", 64'(cam_wr_en), 64'd1);
    chk("wr_index", 64'(cam_wr_index), 64'(a));
    chk("wr_key", 64'(cam_wr_key), 64'(key));
    n = 1;
    while (!wr_ack && n < 12) begin
      chk("no_rd_in_write", 64'(cam_rd_en), 64'd0);
      tick();
      n++;
    end
    chk("wr_latency", 64'(n), 64'd4);
    wr_req = 1'b0;
    tick();
  endtask

  function automatic logic all_out_or();
    return |{lk0_ack, lk0_hit, lk0_match_addr, lk1_ack, lk1_hit, lk1_match_addr,
             wr_ack, cam_rd_en, cam_rd_key, cam_wr_en, cam_wr_key, cam_wr_index};
  endfunction

  // Abort a lookup on `lane` in WAIT, then check both-requesting goes to lk0.
  task automatic reset_abort(input bit lane, input logic [31:0] key);
    if (lane) begin lk1_req = 1'b1; lk1_key = key; end
    else      begin lk0_req = 1'b1; lk0_key = key; end
    tick();                      // LOOKUP
    tick();                      // WAIT
    reset_n = 1'b0;
    #1;
    chk("rst_clear", 64'(all_out_or()), 64'd0);
    lk0_req = 1'b0;
    lk1_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (4) tick();           // monitor flags any stray ack here
    noise = 32'h0;
    lk0_req = 1'b1; lk0_key = 32'h0A000001;
    lk1_req = 1'b1; lk1_key = 32'hC0A80002;
    push_lk(1'b0, 1'b1, 32'h0000_0008);
    push_lk(1'b1, 1'b1, 32'h0000_0080);
    tick();
    chk("rr_after_reset_key", 64'(cam_rd_key), 64'h0A000001);
    repeat (5) tick();
    chk("rr_after_reset_lk1", 64'(lk1_ack), 64'd1);
    lk0_req = 1'b0;
    lk1_req = 1'b0;
    tick();
  endtask

  typedef struct {
    bit          lane;
    logic [31:0] key;
    logic [31:0] nz;
    logic        eh;
    logic [31:0] ea;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1'b0, 32'h0A000001, 32'h0,         1'b1, 32'h0000_0008};
    vecs[1] = '{1'b0, 32'h0A0000FF, 32'h10,        1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'hC0A80002, 32'h0,         1'b1, 32'h0000_0080};
    vecs[3] = '{1'b1, 32'hDEADBEEF, 32'h0,         1'b1, 32'h8000_0000};
    vecs[4] = '{1'b0, 32'h01020304, 32'h0,         1'b1, 32'h0000_0001};
    vecs[5] = '{1'b1, 32'h12345678, 32'hFFFF_FFFF, 1'b0, 32'h0};

    lk0_req = 1'b0; lk1_req = 1'b0; wr_req = 1'b0;
    lk0_key = '0; lk1_key = '0; wr_key = '0; wr_addr = '0;
`ifdef CAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk("reset_outputs", 64'(all_out_or()), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // table-driven lookups (last one on lk1, so lk0 wins the next tie)
    for (int i = 0; i < 6; i++)
      do_lookup(vecs[i].lane, vecs[i].key, vecs[i].nz, vecs[i].eh, vecs[i].ea);

    // round robin with both held continuously
    noise = 32'h0;
    lk0_req = 1'b1; lk0_key = 32'h0A000001;
    lk1_req = 1'b1; lk1_key = 32'hC0A80002;
    for (int j = 0; j < 2; j++) begin
      push_lk(1'b0, 1'b1, 32'h0000_0008);
      push_lk(1'b1, 1'b1, 32'h0000_0080);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 3 == 0) begin
        chk("rr_lk0_ack", 64'(lk0_ack), 64'((i / 3) % 2));
        chk("rr_lk1_ack", 64'(lk1_ack), 64'(1 - (i / 3) % 2));
      end
    end
    lk0_req = 1'b0;
    lk1_req = 1'b0;
    tick();

    // write and lookup requested in the same cycle: write first
    begin
      exp_t e;
      wr_req = 1'b1; wr_addr = 5'd5; wr_key = 32'hC0A80001;
      lk0_req = 1'b1; lk0_key = 32'hC0A80001;
      e.kind = 2'd2; e.hit = 1'b0; e.addr = 32'h0;
      sb.push_back(e);
      push_lk(1'b0, 1'b1, 32'h0000_0020);
      tick();                                     // T+1
      chk("col_wr_en", 64'(cam_wr_en), 64'd1);
      chk("col_wr_index", 64'(cam_wr_index), 64'd5);
      chk("col_wr_key", 64'(cam_wr_key), 64'hC0A80001);
      chk("col_no_rd_t1", 64'(cam_rd_en), 64'd0);
      tick();                                     // T+2
      chk("col_no_rd_t2", 64'(cam_rd_en), 64'd0);
      tick();                                     // T+3
      chk("col_no_rd_t3", 64'(cam_rd_en), 64'd0);
      tick();                                     // T+4
      chk("col_wr_ack", 64'(wr_ack), 64'd1);
      chk("col_no_rd_t4", 64'(cam_rd_en), 64'd0);
      wr_req = 1'b0;
      tick();                                     // T+5
      chk("col_rd_en_t5", 64'(cam_rd_en), 64'd1);
      chk("col_rd_key_t5", 64'(cam_rd_key), 64'hC0A80001);
      tick();
      tick();                                     // T+7
      chk("col_lk0_ack_t7", 64'(lk0_ack), 64'd1);
      lk0_req = 1'b0;
      tick();
    end

    // reset in WAIT of an lk1 lookup, then of an lk0 lookup
    reset_abort(1'b1, 32'hC0A80002);
    reset_abort(1'b0, 32'h0A000001);

`ifdef CAM_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    do_write(5'd10, 32'h11110000);
    do_write(5'd11, 32'h22220000);
    do_lookup(1'b0, 32'h0A000001, 32'h0, 1'b1, 32'h0000_0008);
    do_lookup(1'b1, 32'h11110000, 32'h0, 1'b1, 32'h0000_0400);
    do_lookup(1'b0, 32'h55555555, 32'h4, 1'b0, 32'h0);
    do_lookup(1'b1, 32'h22220000, 32'h0, 1'b1, 32'h0000_0800);
    chk("stat_lookups", 64'(stat_lookups), 64'd4);
    chk("stat_hits", 64'(stat_hits), 64'd3);
    chk("stat_writes", 64'(stat_writes), 64'd2);
    lk0_req = 1'b1; lk0_key = 32'hDEADBEEF;
    push_lk(1'b0, 1'b1, 32'h8000_0000);
    tick();
    tick();
    tick();
    chk("stat5_ack", 64'(lk0_ack), 64'd1);
    stats_clr = 1'b1;
    lk0_req = 1'b0;
    tick();
    stats_clr = 1'b0;
    chk("stat_clr_all", {stat_lookups, stat_hits | stat_writes}, 64'h0);
`endif

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
